playfield_engine: RTL and testbench
===================================

// Module: playfield_engine
// PURPOSE
//  Owns the Tetris playfield that color_mapper renders.
//  - Accepts locked pieces (4 cells + colour) over a valid/ready handshake and writes them into the field.
//  - Scans for full rows, collapses them one at a time and reports lines cleared.
//  - Drives grid[COLS][ROWS] directly into color_mapper; rows 0-1 are hidden spawn rows.
// PARAMETERS
//  COLS  10  playfield width in cells
//  ROWS  22  playfield height in cells; row 0 = top, row ROWS-1 = bottom
//  CW    3   cell code width; 0 = empty, 1..7 = piece colour
// PORTS
//  Clk           in   1      system clock
//  Reset_n       in   1      asynchronous, active-low reset
//  clear_all     in   1      sync request to empty the field; honoured in IDLE only
//  lock_valid    in   1      piece-lock request
//  lock_ready    out  1      high when a lock can be accepted: (state==IDLE) && !clear_all
//  lock_x[4]     in   4 ea   column of each of the 4 cells
//  lock_y[4]     in   5 ea   row of each of the 4 cells
//  lock_color    in   CW     colour code written to all 4 cells
//  grid[COLS][ROWS] out CW   registered playfield, consumed by color_mapper
//  busy          out  1      high in every state except IDLE
//  clear_done    out  1      one-cycle pulse when processing of a lock completes
//  lines_cleared out  3      rows removed by the last lock (0..4); held until the next DONE
//  lines_total   out  16     running total of cleared lines; saturates at 16'hFFFF
//  top_out       out  1      sticky flag: a cell in rows 0-1 is nonzero after a collapse
// BEHAVIOUR
//  Reset (Reset_n=0, any state, any cycle):
//   - All grid cells = 0, state = IDLE.
//   - busy = 0, clear_done = 0, lines_cleared = 0, lines_total = 0, top_out = 0. lock_ready is then 1.
//  FSM: IDLE -> WRITE -> SCAN <-> SHIFT -> DONE -> IDLE
//  IDLE:
//   - clear_all=1: zero all cells and clear top_out in that cycle; stay in IDLE.
//     clear_all wins over lock_valid in the same cycle, which is not accepted.
//   - Otherwise lock_valid && lock_ready: capture the x/y/colour inputs -> WRITE.
//  WRITE (1 cycle):
//   - Write lock_color to the 4 captured cells.
//   - A cell with x>=COLS or y>=ROWS is dropped silently; the other cells are still written.
//   - Duplicate coordinates are written once.
//   - Set row pointer r=ROWS-1 and per-lock counter k=0 -> SCAN.
//  SCAN (1 cycle per row): row r is full when all COLS cells are nonzero.
//   - Full: go to SHIFT.
//   - Not full and r==0: go to DONE.
//   - Not full and r>0: r=r-1, stay in SCAN.
//  SHIFT (1 cycle):
//   - Rows 0..r-1 move down one row at once; row 0 fills with zeros.
//   - k=k+1; r is unchanged so the same row is rescanned -> SCAN.
//  DONE (1 cycle):
//   - clear_done=1, lines_cleared=k.
//   - lines_total += k, saturating.
//   - top_out |= (any nonzero cell in rows 0-1).
//   - -> IDLE.
//  Latency:
//   - Lock accepted on edge 0: WRITE in cycle 1, SCAN from cycle 2, DONE in cycle 24+2k (ROWS=22).
//   - Next lock can be accepted in cycle 25+2k.
//  grid changes only in WRITE, SHIFT and clear_all. color_mapper may read it at any time;
//  tearing mid-frame is acceptable.
//  lock_valid and clear_all are ignored while busy. The requester must hold lock_valid until lock_ready.
// CONFIGURATION
//  PF_SCORE_EN defined:
//   - Adds output score (24 bits), reset to 0 and also cleared by clear_all.
//   - In DONE, score += {0,40,100,300,1200}[k], saturating at 24'hFFFFFF.
//   - Score changes in the same cycle as clear_done.
//  PF_SCORE_EN undefined:
//   - No score port and no score logic; all other behaviour is identical.
// TESTING
//  1 Reset: Reset_n=0 mid-SHIFT -> same cycle all grid=0, busy=0, lines_total=0; lock_ready=1 after release.
//  2 Single lock on an empty field: cells (4,21)(5,21)(4,20)(5,20), colour 3
//    -> those 4 cells=3, clear_done in cycle 24, lines_cleared=0.
//  3 Single clear: row 21 cols 0-5 preloaded, lock fills cols 6-9 of row 21 plus row 20 above a colour-2 cell
//    -> row 21 takes the old row 20, lines_cleared=1, clear_done in cycle 26.
//  4 Tetris: rows 18-21 full except col 9; vertical I, colour 1, at x=9, y=18..21
//    -> rows 18-21 empty, lines_cleared=4, lines_total+=4, clear_done in cycle 32; score+=1200 if PF_SCORE_EN.
//  5 Non-adjacent clears: rows 21 and 19 become full, row 20 does not
//    -> lines_cleared=2, old row 20 lands in row 21.
//  6 Edge cases:
//    - clear_all and lock_valid in the same IDLE cycle -> field zeroed, lock not accepted.
//    - Lock with x=12 -> that cell dropped, other cells written.
//    - Lock into row 1 -> top_out=1 at DONE.

Source files
------------

// File: rtl/playfield_engine.sv
// playfield_engine: Tetris playfield store with piece locking, full-row collapse and line statistics.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_all_i            empty the field (honoured in IDLE only, beats a same-cycle lock)
//   lock_valid_i/ready_o   piece-lock handshake; lock_x_i/lock_y_i/lock_color_i give 4 cells + colour
//   grid_o[COLS][ROWS]     registered playfield; row 0 is the top, rows 0-1 are hidden spawn rows
//   busy_o                 high outside IDLE
//   clear_done_o           one-cycle pulse when a lock has been fully processed
//   lines_cleared_o        rows removed by the last lock, held until the next completion
//   lines_total_o          saturating running total of cleared rows
//   top_out_o              sticky: a spawn-row cell was occupied after a collapse
//   score_o                only when PF_SCORE_EN is defined: saturating 0/40/100/300/1200 scoring
module playfield_engine #(
    parameter int COLS = 10,
    parameter int ROWS = 22,
    parameter int CW   = 3
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_all_i,
    input  logic          lock_valid_i,
    output logic          lock_ready_o,
    input  logic [3:0]    lock_x_i [4],
    input  logic [4:0]    lock_y_i [4],
    input  logic [CW-1:0] lock_color_i,
    output logic [CW-1:0] grid_o [COLS][ROWS],
    output logic          busy_o,
    output logic          clear_done_o,
    output logic [2:0]    lines_cleared_o,
    output logic [15:0]   lines_total_o,
    output logic          top_out_o
`ifdef PF_SCORE_EN
    ,
    output logic [23:0]   score_o
`endif
);
    localparam int RW = $clog2(ROWS);
    typedef enum logic [2:0] {IDLE, WRITE, SCAN, SHIFT, DONE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] grid_q [COLS][ROWS];
    logic [CW-1:0] grid_d [COLS][ROWS];
    logic [3:0]    x_q [4];
    logic [3:0]    x_d [4];
    logic [4:0]    y_q [4];
    logic [4:0]    y_d [4];
    logic [CW-1:0] color_q, color_d;
    logic [RW-1:0] r_q, r_d;
    logic [2:0]    k_q, k_d, cleared_q, cleared_d;
    logic [15:0]   total_q, total_d;
    logic          top_q, top_d, row_full, top_any;
    logic [16:0]   total_sum;
`ifdef PF_SCORE_EN
    logic [23:0]   score_q, score_d;
    logic [24:0]   score_sum;
    logic [10:0]   pts;
`endif
    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) if (grid_q[c][r_q] == '0) row_full = 1'b0;
        top_any = 1'b0;
        for (int c = 0; c < COLS; c++)
            for (int y = 0; y < 2; y++) if (grid_q[c][y] != '0) top_any = 1'b1;
        total_sum = {1'b0, total_q} + 17'(k_q);
        state_d   = state_q;
        grid_d    = grid_q;
        x_d       = x_q;
        y_d       = y_q;
        color_d   = color_q;
        r_d       = r_q;
        k_d       = k_q;
        cleared_d = cleared_q;
        total_d   = total_q;
        top_d     = top_q;
`ifdef PF_SCORE_EN
        pts = (k_q == 3'd1) ? 11'd40 : (k_q == 3'd2) ? 11'd100 :
              (k_q == 3'd3) ? 11'd300 : (k_q == 3'd4) ? 11'd1200 : 11'd0;
        score_sum = {1'b0, score_q} + 25'(pts);
        score_d   = score_q;
`endif
        case (state_q)
            IDLE: begin
                if (clear_all_i) begin
                    for (int c = 0; c < COLS; c++)
                        for (int y = 0; y < ROWS; y++) grid_d[c][y] = '0;
                    top_d = 1'b0;
`ifdef PF_SCORE_EN
                    score_d = '0;
`endif
                end else if (lock_valid_i) begin
                    x_d     = lock_x_i;
                    y_d     = lock_y_i;
                    color_d = lock_color_i;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Out-of-range cells match no grid position and are dropped; duplicates just rewrite.
                for (int c = 0; c < COLS; c++)
                    for (int y = 0; y < ROWS; y++)
                        for (int i = 0; i < 4; i++)
                            if (int'(x_q[i]) == c && int'(y_q[i]) == y) grid_d[c][y] = color_q;
                r_d     = RW'(ROWS - 1);
                k_d     = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (row_full) begin
                    state_d = SHIFT;
                end else if (r_q == '0) begin
                    // Statistics are registered on entry to DONE so they change alongside clear_done.
                    cleared_d = k_q;
                    total_d   = total_sum[16] ? 16'hFFFF : total_sum[15:0];
                    top_d     = top_q | top_any;
`ifdef PF_SCORE_EN
                    score_d   = score_sum[24] ? 24'hFFFFFF : score_sum[23:0];
`endif
                    state_d   = DONE;
                end else begin
                    r_d = r_q - RW'(1);
                end
            end
            SHIFT: begin
                for (int c = 0; c < COLS; c++) begin
                    grid_d[c][0] = '0;
                    for (int y = 1; y < ROWS; y++)
                        if (y <= int'(r_q)) grid_d[c][y] = grid_q[c][y-1];
                end
                k_d     = k_q + 3'd1;
                state_d = SCAN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            for (int c = 0; c < COLS; c++)
                for (int y = 0; y < ROWS; y++) grid_q[c][y] <= '0;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            color_q   <= '0;
            r_q       <= '0;
            k_q       <= '0;
            cleared_q <= '0;
            total_q   <= '0;
            top_q     <= 1'b0;
`ifdef PF_SCORE_EN
            score_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            x_q       <= x_d;
            y_q       <= y_d;
            color_q   <= color_d;
            r_q       <= r_d;
            k_q       <= k_d;
            cleared_q <= cleared_d;
            total_q   <= total_d;
            top_q     <= top_d;
`ifdef PF_SCORE_EN
            score_q   <= score_d;
`endif
        end
    end
    assign grid_o          = grid_q;
    assign busy_o          = state_q != IDLE;
    assign lock_ready_o    = state_q == IDLE && !clear_all_i;
    assign clear_done_o    = state_q == DONE;
    assign lines_cleared_o = cleared_q;
    assign lines_total_o   = total_q;
    assign top_out_o       = top_q;
`ifdef PF_SCORE_EN
    assign score_o         = score_q;
`endif
endmodule

// File: tb/tb_playfield_engine.sv
// tb_playfield_engine: directed locks checked every cycle against a row-compaction model of the field.
module tb_playfield_engine;
    localparam int COLS = 10, ROWS = 22, CW = 3;
    logic clk = 1'b0, rst_n = 1'b0, clear_all = 1'b0, lock_valid = 1'b0;
    logic lock_ready, busy, clear_done, top_out;
    logic [3:0]    lock_x [4];
    logic [4:0]    lock_y [4];
    logic [CW-1:0] lock_color = '0;
    logic [CW-1:0] grid [COLS][ROWS];
    logic [2:0]    lines_cleared;
    logic [15:0]   lines_total;
`ifdef PF_SCORE_EN
    logic [23:0]   score;
`endif
    int n_cmp = 0, n_bad = 0;
    int m_cur [COLS][ROWS];
    int m_wr  [COLS][ROWS];
    int m_new [COLS][ROWS];
    int m_k, m_d, m_lines = 0, m_total = 0, m_top = 0, m_score = 0, t = 0, done_t = -1;
    bit active = 1'b0, chk_en = 1'b0;

    always #5 clk = ~clk;

    playfield_engine #(.COLS(COLS), .ROWS(ROWS), .CW(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_all_i(clear_all), .lock_valid_i(lock_valid),
        .lock_ready_o(lock_ready), .lock_x_i(lock_x), .lock_y_i(lock_y), .lock_color_i(lock_color),
        .grid_o(grid), .busy_o(busy), .clear_done_o(clear_done), .lines_cleared_o(lines_cleared),
        .lines_total_o(lines_total), .top_out_o(top_out)
`ifdef PF_SCORE_EN
        , .score_o(score)
`endif
    );

    function automatic void chk(string name, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void grid_chk(string name, int exp [COLS][ROWS]);
        bit bad = 1'b0;
        n_cmp++;
        for (int c = 0; c < COLS; c++)
            for (int y = 0; y < ROWS; y++)
                if (!bad && int'(grid[c][y]) != exp[c][y]) begin
                    bad = 1'b1;
                    $display("FAIL %s: cell (%0d,%0d) got %0d expected %0d", name, c, y, grid[c][y], exp[c][y]);
                end
        if (bad) n_bad++;
    endfunction

    // Field after a lock: drop every full row and let the survivors settle to the bottom in order.
    function automatic void model_lock(int xs [4], int ys [4], int col);
        int dst;
        bit full;
        m_wr = m_cur;
        for (int i = 0; i < 4; i++) if (xs[i] < COLS && ys[i] < ROWS) m_wr[xs[i]][ys[i]] = col;
        for (int c = 0; c < COLS; c++) for (int y = 0; y < ROWS; y++) m_new[c][y] = 0;
        dst = ROWS - 1;
        m_k = 0;
        for (int y = ROWS - 1; y >= 0; y--) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++) if (m_wr[c][y] == 0) full = 1'b0;
            if (full) m_k++;
            else begin
                for (int c = 0; c < COLS; c++) m_new[c][dst] = m_wr[c][y];
                dst--;
            end
        end
        m_d = ROWS + 2 + 2 * m_k;
    endfunction

    function automatic void model_commit();
        int pts [5] = '{0, 40, 100, 300, 1200};
        m_cur   = m_new;
        m_lines = m_k;
        m_total = (m_total + m_k > 65535) ? 65535 : m_total + m_k;
        m_score = (m_score + pts[m_k] > 24'hFFFFFF) ? 24'hFFFFFF : m_score + pts[m_k];
        for (int c = 0; c < COLS; c++) for (int y = 0; y < 2; y++) if (m_new[c][y] != 0) m_top = 1;
    endfunction

    function automatic void model_zero();
        for (int c = 0; c < COLS; c++) for (int y = 0; y < ROWS; y++) m_cur[c][y] = 0;
        m_top   = 0;
        m_score = 0;
    endfunction

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            if (active) begin
                t++;
                if (clear_done && done_t < 0) done_t = t;
                chk("busy", busy, t <= m_d);
                chk("clear_done", clear_done, t == m_d);
                chk("lock_ready_busy", lock_ready, 0);
                if (t == 1) grid_chk("grid_before_write", m_cur);
                if (t == 2) grid_chk("grid_after_write", m_wr);
                if (t == m_d) begin
                    model_commit();
                    grid_chk("grid_at_done", m_cur);
                    chk("lines_cleared_done", lines_cleared, m_lines);
                    chk("lines_total_done", lines_total, m_total);
                    chk("top_out_done", top_out, m_top);
`ifdef PF_SCORE_EN
                    chk("score_done", score, m_score);
`endif
                    active = 1'b0;
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_clear_done", clear_done, 0);
                chk("idle_lock_ready", lock_ready, !clear_all);
                chk("idle_lines_cleared", lines_cleared, m_lines);
                chk("idle_lines_total", lines_total, m_total);
                chk("idle_top_out", top_out, m_top);
`ifdef PF_SCORE_EN
                chk("idle_score", score, m_score);
`endif
                grid_chk("idle_grid", m_cur);
            end
        end
    end

    task automatic start_lock(input int xs [4], input int ys [4], input int col);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            lock_x[i] = 4'(xs[i]);
            lock_y[i] = 5'(ys[i]);
        end
        lock_color = CW'(col);
        lock_valid = 1'b1;
        @(posedge clk);
        #1;
        lock_valid = 1'b0;
        model_lock(xs, ys, col);
        t      = 0;
        done_t = -1;
        active = 1'b1;
    endtask

    task automatic do_lock(input int xs [4], input int ys [4], input int col);
        start_lock(xs, ys, col);
        for (int n = 0; n < 100 && active; n++) @(negedge clk);
        if (active) chk("lock_timeout", 1, 0);
    endtask

    task automatic do_clear(input bit with_lock);
        @(posedge clk);
        #1;
        clear_all  = 1'b1;
        lock_valid = with_lock;
        @(posedge clk);
        #1;
        clear_all  = 1'b0;
        lock_valid = 1'b0;
        model_zero();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            lock_x[i] = '0;
            lock_y[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        grid_chk("rst_grid", m_cur);
        chk("rst_busy", busy, 0);
        chk("rst_lines_total", lines_total, 0);
        chk("rst_top_out", top_out, 0);
        chk("rst_lock_ready", lock_ready, 1);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        // Single lock on an empty field.
        do_lock('{4, 5, 4, 5}, '{21, 21, 20, 20}, 3);
        chk("t2_cell_4_21", grid[4][21], 3);
        chk("t2_cell_5_20", grid[5][20], 3);
        chk("t2_lines_cleared", lines_cleared, 0);
        chk("t2_done_cycle", done_t, 24);
        // clear_all beats a simultaneous lock request.
        do_clear(1'b1);
        repeat (2) @(negedge clk);
        chk("t6_clear_busy", busy, 0);
        chk("t6_clear_cell", grid[4][21], 0);
        // Single clear with a colour-2 cell above the completed row.
        do_lock('{0, 1, 2, 3}, '{21, 21, 21, 21}, 5);
        do_lock('{4, 5, 0, 0}, '{21, 21, 20, 20}, 2);
        do_lock('{6, 7, 8, 9}, '{21, 21, 21, 21}, 4);
        chk("t3_cell_0_21", grid[0][21], 2);
        chk("t3_cell_4_21", grid[4][21], 0);
        chk("t3_lines_cleared", lines_cleared, 1);
        chk("t3_done_cycle", done_t, 26);
        chk("t3_lines_total", lines_total, 1);
        // Tetris: rows 18-21 full except column 9, then a vertical I.
        do_clear(1'b0);
        for (int c = 0; c < 9; c++) do_lock('{c, c, c, c}, '{18, 19, 20, 21}, c % 7 + 1);
        do_lock('{9, 9, 9, 9}, '{18, 19, 20, 21}, 1);
        chk("t4_lines_cleared", lines_cleared, 4);
        chk("t4_lines_total", lines_total, 5);
        chk("t4_done_cycle", done_t, 32);
        chk("t4_cell_0_21", grid[0][21], 0);
        chk("t4_cell_9_18", grid[9][18], 0);
`ifdef PF_SCORE_EN
        chk("t4_score", score, 1200);
`endif
        // Non-adjacent clears: rows 21 and 19 complete, row 20 holds one cell.
        do_clear(1'b0);
        do_lock('{0, 1, 2, 3}, '{21, 21, 21, 21}, 2);
        do_lock('{4, 5, 6, 7}, '{21, 21, 21, 21}, 3);
        do_lock('{0, 1, 2, 3}, '{19, 19, 19, 19}, 4);
        do_lock('{4, 5, 6, 7}, '{19, 19, 19, 19}, 5);
        do_lock('{0, 0, 0, 0}, '{20, 20, 20, 20}, 6);
        do_lock('{8, 9, 8, 9}, '{21, 21, 19, 19}, 7);
        chk("t5_lines_cleared", lines_cleared, 2);
        chk("t5_cell_0_21", grid[0][21], 6);
        chk("t5_cell_1_21", grid[1][21], 0);
        chk("t5_cell_0_20", grid[0][20], 0);
        chk("t5_done_cycle", done_t, 28);
        chk("t5_lines_total", lines_total, 7);
        // Out-of-range cells are dropped, the rest still land.
        do_lock('{12, 3, 4, 6}, '{10, 10, 10, 25}, 5);
        chk("t6_oob_cell_3_10", grid[3][10], 5);
        chk("t6_oob_cell_4_10", grid[4][10], 5);
        chk("t6_oob_cell_2_10", grid[2][10], 0);
        chk("t6_oob_lines", lines_cleared, 0);
        // Spawn-row occupancy sets top_out; clear_all resets it.
        chk("t6_top_before", top_out, 0);
        do_lock('{0, 1, 2, 3}, '{1, 1, 1, 1}, 2);
        chk("t6_top_after", top_out, 1);
        chk("t6_cell_0_1", grid[0][1], 2);
        do_clear(1'b0);
        @(negedge clk);
        chk("t6_top_cleared", top_out, 0);
        // Asynchronous reset while a row is collapsing.
        do_lock('{0, 1, 2, 3}, '{21, 21, 21, 21}, 1);
        do_lock('{4, 5, 6, 7}, '{21, 21, 21, 21}, 2);
        chk("t1_total_pre", lines_total, 7);
        start_lock('{8, 9, 8, 9}, '{21, 21, 20, 20}, 3);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("t1_busy_pre", busy, 1);
        rst_n  = 1'b0;
        active = 1'b0;
        model_zero();
        m_total = 0;
        m_lines = 0;
        #1;
        grid_chk("t1_rst_grid", m_cur);
        chk("t1_rst_busy", busy, 0);
        chk("t1_rst_lines_total", lines_total, 0);
        chk("t1_rst_clear_done", clear_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_lock_ready", lock_ready, 1);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
        $fatal(1);
    end
endmodule
